// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the execute-stage hazard controller: forwarding selects,
// controller FSM states and the default register-address width.
package ex_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 3;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwdSelE;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HALT  = 2'b10
  } ctrlStateE;

endpackage

// File: rtl/hazard_slot.sv
// One shadow slot tracking the destination of the instruction in a pipeline stage.
// A bubble loads an empty slot, which can never match a source register.
module hazard_slot #(
  parameter int unsigned REG_W = ex_hazard_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic             dValid,
  input  logic             dWrEn,
  input  logic [REG_W-1:0] dWrReg,
  input  logic             dIsLoad,
  output logic             qValid,
  output logic             qWrEn,
  output logic [REG_W-1:0] qWrReg,
  output logic             qIsLoad
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qValid  <= 1'b0;
      qWrEn   <= 1'b0;
      qWrReg  <= '0;
      qIsLoad <= 1'b0;
    end else if (bubble) begin
      qValid  <= 1'b0;
      qWrEn   <= 1'b0;
      qWrReg  <= '0;
      qIsLoad <= 1'b0;
    end else begin
      qValid  <= dValid;
      qWrEn   <= dWrEn;
      qWrReg  <= dWrReg;
      qIsLoad <= dIsLoad;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: registered operand forwarding selects, load-use
// stall/bubble, branch flush, sticky halt on execute error, saturating event counters.
module ex_hazard_ctrl #(
  parameter int unsigned REG_W = ex_hazard_ctrl_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_use,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rt_use,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             ex_err,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import ex_hazard_ctrl_pkg::*;

  logic             exValid, exWrEn, exIsLoad;
  logic [REG_W-1:0] exWrReg;
  logic             memValid, memWrEn, memIsLoad;
  logic [REG_W-1:0] memWrReg;
  logic             wbValid, wbWrEn, wbIsLoad;
  logic [REG_W-1:0] wbWrReg;

  hazard_slot #(.REG_W(REG_W)) uExSlot (
    .clk(clk), .rst(rst), .bubble(bubble_ex),
    .dValid(id_valid), .dWrEn(id_wr_en), .dWrReg(id_wr_reg), .dIsLoad(id_is_load),
    .qValid(exValid), .qWrEn(exWrEn), .qWrReg(exWrReg), .qIsLoad(exIsLoad)
  );

  hazard_slot #(.REG_W(REG_W)) uMemSlot (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .dValid(exValid), .dWrEn(exWrEn), .dWrReg(exWrReg), .dIsLoad(exIsLoad),
    .qValid(memValid), .qWrEn(memWrEn), .qWrReg(memWrReg), .qIsLoad(memIsLoad)
  );

  hazard_slot #(.REG_W(REG_W)) uWbSlot (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .dValid(memValid), .dWrEn(memWrEn), .dWrReg(memWrReg), .dIsLoad(memIsLoad),
    .qValid(wbValid), .qWrEn(wbWrEn), .qWrReg(wbWrReg), .qIsLoad(wbIsLoad)
  );

  // WB results reach EX through the register file, so the WB slot only drains.
  logic unusedSlotBits;
  assign unusedSlotBits = ^{memIsLoad, wbValid, wbWrEn, wbWrReg, wbIsLoad};

  logic exHitA, exHitB, memHitA, memHitB, loadUse;
  assign exHitA  = exValid  & exWrEn  & (exWrReg  == id_rs) & id_rs_use;
  assign exHitB  = exValid  & exWrEn  & (exWrReg  == id_rt) & id_rt_use;
  assign memHitA = memValid & memWrEn & (memWrReg == id_rs) & id_rs_use;
  assign memHitB = memValid & memWrEn & (memWrReg == id_rt) & id_rt_use;
  assign loadUse = id_valid & exIsLoad & (exHitA | exHitB);

  ctrlStateE state, nextState;

  always_comb begin
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    nextState   = state;
    if (state == HALT) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else begin
      flush_if_id = ex_br_taken;
      bubble_ex   = ex_br_taken | loadUse;
      stall_if_id = loadUse & ~ex_br_taken;
    end
    if (ex_err) begin
      nextState = HALT;
    end else begin
      case (state)
        RUN:     if (loadUse && !ex_br_taken) nextState = STALL;
        STALL:   nextState = RUN;
        default: nextState = HALT;
      endcase
    end
    // Strobes are forced low for the whole reset assertion, not just after the edge.
    if (!rst) begin
      stall_if_id = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= nextState;
  end

  assign halted = (state == HALT);

  fwdSelE fwdA, fwdB, nextFwdA, nextFwdB;

  always_comb begin
    nextFwdA = FWD_RF;
    nextFwdB = FWD_RF;
    if (!bubble_ex && id_valid) begin
      if (exHitA)       nextFwdA = FWD_EXMEM;
      else if (memHitA) nextFwdA = FWD_MEMWB;
      if (exHitB)       nextFwdB = FWD_EXMEM;
      else if (memHitB) nextFwdB = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwdA <= FWD_RF;
      fwdB <= FWD_RF;
    end else begin
      fwdA <= nextFwdA;
      fwdB <= nextFwdB;
    end
  end

  assign fwd_a_sel = fwdA;
  assign fwd_b_sel = fwdB;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      if (stall_if_id && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if_id && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
